vga_pixel_driver: RTL

//  Display-side end of the pixel pipeline: generates 640x480@60 VGA scan timing and

---
 rtl/vga_pixel_driver.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/vga_pixel_driver.sv
// 640x480@60 VGA scan generator: publishes pixelX/pixelY to the drawing objects, realigns
// sync/blank with the returning pixel after PIPE_LAT steps and drives a 4:4:4 DAC.
module vga_pixel_driver #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int PIPE_LAT = 2,
    parameter int CLK_DIV  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  RGBIn,
    output logic [10:0] pixelX,
    output logic [10:0] pixelY,
    output logic        frameTick,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        hsync,
    output logic        vsync,
    output logic        blankN
);

    localparam logic [10:0] H_LAST     = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [10:0] V_LAST     = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [10:0] H_VIS      = 11'(H_ACTIVE);
    localparam logic [10:0] V_VIS      = 11'(V_ACTIVE);
    localparam logic [10:0] HS_FIRST   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_LAST    = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] VS_FIRST   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_LAST    = 11'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [10:0] V_VIS_PREV = 11'(V_ACTIVE - 1);
    // Delay-line entry is {act, hs, vs}; idle means blanked with both syncs released.
    localparam logic [2:0]  IDLE_ATTR  = 3'b011;
    localparam int          DLY_W      = 3 * PIPE_LAT;

    logic pe;

    generate
        if (CLK_DIV == 2) begin : g_div
            logic div_q, div_d;
            always_comb div_d = ~div_q;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) div_q <= 1'b0;
                else       div_q <= div_d;
            end
            assign pe = div_q;
        end else begin : g_nodiv
            assign pe = 1'b1;
        end
    endgenerate

    logic [10:0] h_q, h_d, v_q, v_d;
    logic        act, hs, vs;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic [DLY_W+2:0] dly_shift;
    logic [2:0]  last_attr;
    logic [3:0]  red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic        hsync_q, hsync_d, vsync_q, vsync_d, blank_n_q, blank_n_d;
    logic        tick_q, tick_d;

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (pe) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 11'd1;
            end else begin
                h_d = h_q + 11'd1;
            end
        end
    end

    always_comb begin
        act = (h_q < H_VIS) && (v_q < V_VIS);
        hs  = !((h_q >= HS_FIRST) && (h_q <= HS_LAST));
        vs  = !((v_q >= VS_FIRST) && (v_q <= VS_LAST));
    end

    // Shift in at the bottom; the widened vector keeps PIPE_LAT == 1 free of special cases.
    always_comb begin
        dly_shift = {dly_q, act, hs, vs};
        dly_d     = pe ? dly_shift[DLY_W-1:0] : dly_q;
        last_attr = dly_q[DLY_W-1 -: 3];
    end

    always_comb begin
        red_d     = red_q;
        green_d   = green_q;
        blue_d    = blue_q;
        hsync_d   = hsync_q;
        vsync_d   = vsync_q;
        blank_n_d = blank_n_q;
        if (pe) begin
            blank_n_d = last_attr[2];
            hsync_d   = last_attr[1];
            vsync_d   = last_attr[0];
            red_d     = last_attr[2] ? {RGBIn[7:5], RGBIn[7]}   : 4'd0;
            green_d   = last_attr[2] ? {RGBIn[4:2], RGBIn[4]}   : 4'd0;
            blue_d    = last_attr[2] ? {RGBIn[1:0], RGBIn[1:0]} : 4'd0;
        end
        // Fires on the same clk that the counters land on (0, V_ACTIVE).
        tick_d = pe && (h_q == H_LAST) && (v_q == V_VIS_PREV);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_q       <= '0;
            v_q       <= '0;
            dly_q     <= {PIPE_LAT{IDLE_ATTR}};
            red_q     <= '0;
            green_q   <= '0;
            blue_q    <= '0;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
            blank_n_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            h_q       <= h_d;
            v_q       <= v_d;
            dly_q     <= dly_d;
            red_q     <= red_d;
            green_q   <= green_d;
            blue_q    <= blue_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            blank_n_q <= blank_n_d;
            tick_q    <= tick_d;
        end
    end

    assign pixelX    = h_q;
    assign pixelY    = v_q;
    assign frameTick = tick_q;
    assign red       = red_q;
    assign green     = green_q;
    assign blue      = blue_q;
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign blankN    = blank_n_q;

endmodule
